sender_arbiter: RTL and testbench

SENDER_ARBITER -- requirements
Module: sender_arbiter

---
 rtl/sender_pkg.sv | 30 +++
 rtl/sender_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/sender_arbiter.sv | 146 ++++++++++++++
 tb/tb_sender_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sender_pkg.sv
// Shared types and sizing for the burst sender arbiter.
package sender_pkg;

  localparam int N_CLIENTS     = 4;
  localparam int BURST_LEN     = 16;
  localparam int START_TIMEOUT = 8;
  localparam int WORD_W        = 16;

  localparam int IDX_W  = $clog2(N_CLIENTS);
  localparam int WCNT_W = $clog2(BURST_LEN);
  localparam int TCNT_W = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index of the set bit of a one-hot client vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_CLIENTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sender_arbiter_if.sv
// Client-side and sender-side signals of the arbiter, bundled as one interface.
interface sender_arbiter_if;
  import sender_pkg::*;

  logic [N_CLIENTS-1:0]        ClientReq;
  logic [N_CLIENTS*WORD_W-1:0] ClientData;
  logic [N_CLIENTS-1:0]        Grant;
  logic [N_CLIENTS-1:0]        Next;
  logic                        Transmit;
  logic [WORD_W-1:0]           TxData;
  logic                        Request;
  logic                        Ready;
  logic                        Busy;
  logic                        BurstDone;
  logic                        Error;

  // Environment side: clients plus the sender.
  modport master (
    output ClientReq, ClientData, Request, Ready,
    input  Grant, Next, Transmit, TxData, Busy, BurstDone, Error
  );

  // Arbiter side.
  modport slave (
    input  ClientReq, ClientData, Request, Ready,
    output Grant, Next, Transmit, TxData, Busy, BurstDone, Error
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter
  import sender_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [N_CLIENTS-1:0] gnt
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan ptr+1 .. ptr+N (mod N); the last candidate is ptr itself.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sender_arbiter.sv
// Burst arbiter: hands the sender to one client at a time for a 16-word burst.
//
//  state | meaning
//  IDLE  | no owner; grant the next round-robin requester
//  START | owner chosen, Transmit high, waiting for the sender's Request
//  BURST | sender moving words; each Request falling edge is one word
//  DONE  | single cycle after the last word; BurstDone, pointer updated
module sender_arbiter
  import sender_pkg::*;
(
  input  logic            clk,
  input  logic            Reset_n,
  sender_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic [N_CLIENTS-1:0]  grant_q, grant_d;
  logic [N_CLIENTS-1:0]  next_q, next_d;
  logic                  transmit_q, transmit_d;
  logic                  busy_q, busy_d;
  logic                  burst_done_q, burst_done_d;
  logic                  error_q, error_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  req_prev_q, req_prev_d;
  logic [N_CLIENTS-1:0]  rr_gnt;
  logic                  word_done;
  logic [WORD_W-1:0]     tx_data;
  logic                  unused_ready;

  // Ready is observation-only; it never steers the controller.
  assign unused_ready = bus.Ready;

  rr_arbiter u_rr (
    .req (bus.ClientReq),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  assign word_done = req_prev_q & ~bus.Request;

  // State, counters, pointer and registered outputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      next_q       <= '0;
      transmit_q   <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      error_q      <= 1'b0;
      ptr_q        <= IDX_W'(N_CLIENTS - 1);
      tcnt_q       <= '0;
      wcnt_q       <= '0;
      req_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      next_q       <= next_d;
      transmit_q   <= transmit_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
      error_q      <= error_d;
      ptr_q        <= ptr_d;
      tcnt_q       <= tcnt_d;
      wcnt_q       <= wcnt_d;
      req_prev_q   <= req_prev_d;
    end
  end

  // Next-state and output decode; outputs are registered off the next state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    next_d       = '0;
    error_d      = 1'b0;
    ptr_d        = ptr_q;
    tcnt_d       = tcnt_q;
    wcnt_d       = wcnt_q;
    req_prev_d   = bus.Request;

    unique case (state_q)
      IDLE: begin
        if (|bus.ClientReq) begin
          state_d = START;
          grant_d = rr_gnt;
          tcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      START: begin
        if (bus.Request) begin
          state_d = BURST;
        end else if (tcnt_q == TCNT_W'(START_TIMEOUT - 1)) begin
          // Sender never answered: give up without charging the client a turn.
          state_d = IDLE;
          grant_d = '0;
          error_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      BURST: begin
        if (word_done) begin
          next_d = grant_q;
          if (wcnt_q == WCNT_W'(BURST_LEN - 1)) begin
            state_d = DONE;
            grant_d = '0;
            ptr_d   = onehot_to_idx(grant_q);
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    transmit_d   = (state_d == START);
    busy_d       = (state_d == START) || (state_d == BURST);
    burst_done_d = (state_d == DONE);
  end

  // Word mux toward the sender; zero when nobody owns it.
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_q[i]) tx_data = bus.ClientData[i*WORD_W +: WORD_W];
    end
  end

  assign bus.Grant     = grant_q;
  assign bus.Next      = next_q;
  assign bus.Transmit  = transmit_q;
  assign bus.TxData    = tx_data;
  assign bus.Busy      = busy_q;
  assign bus.BurstDone = burst_done_q;
  assign bus.Error     = error_q;

endmodule

// File: tb/tb_sender_arbiter.sv
// Scoreboard bench for sender_arbiter: stimulus queues expected grants and
// burst endings; a negedge monitor pops and checks them as the DUT shows them.
module tb_sender_arbiter;
  import sender_pkg::*;

  localparam int END_DONE = 0;
  localparam int END_ERR  = 1;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  sender_arbiter_if bus ();

  sender_arbiter dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [3:0]  exp_grant[$];
  int          exp_end[$];
  logic [63:0] client_data;

  logic [3:0]  mon_grant;
  logic [3:0]  mon_prev;
  int          mon_next_cnt;
  int          mon_tx_cnt;
  int          mon_kind;
  bit          seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_slice(input logic [3:0] g);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = client_data[i*16 +: 16];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] out_bundle();
    return {bus.Grant, bus.Next, bus.Transmit, bus.TxData, bus.Busy, bus.BurstDone, bus.Error};
  endfunction

  task automatic do_reset(input logic [3:0] req);
    Reset_n       = 1'b0;
    bus.ClientReq = req;
    bus.Request   = 1'b0;
    bus.Ready     = 1'b0;
    #1;
    check("reset_outputs", out_bundle(), 28'h0);
    tick();
    tick();
    check("grant_in_reset", bus.Grant, 4'b0000);
    Reset_n = 1'b1;
    #1;
    check("grant_at_release", bus.Grant, 4'b0000);
  endtask

  task automatic wait_transmit();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.Transmit) seen = 1'b1;
      else tick();
    end
    check("transmit_seen", seen, 1'b1);
  endtask

  // Sender model: Request high one cycle, low one cycle, per word.
  task automatic send_words(input int words);
    for (int w = 0; w < words; w++) begin
      bus.Request = 1'b1;
      bus.Ready   = 1'b0;
      tick();
      bus.Request = 1'b0;
      bus.Ready   = 1'b1;
      tick();
    end
    bus.Ready = 1'b0;
  endtask

  // Monitor: checks grants, Next ownership and burst endings against the queues.
  always @(negedge clk) begin
    if (!Reset_n) begin
      mon_grant    = '0;
      mon_prev     = '0;
      mon_next_cnt = 0;
      mon_tx_cnt   = 0;
    end else begin
      if (bus.Grant != 4'b0000 && mon_prev == 4'b0000) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", bus.Grant, 4'b0000);
        end else begin
          mon_grant = exp_grant.pop_front();
          check("grant", bus.Grant, mon_grant);
          check("transmit_at_grant", bus.Transmit, 1'b1);
          check("busy_at_grant", bus.Busy, 1'b1);
          check("txdata", bus.TxData, exp_slice(mon_grant));
          mon_next_cnt = 0;
          mon_tx_cnt   = 0;
        end
      end
      if (bus.Transmit) mon_tx_cnt++;
      if (bus.Next != 4'b0000) begin
        check("next_owner", bus.Next, mon_grant);
        mon_next_cnt++;
      end
      if (bus.BurstDone || bus.Error) begin
        if (exp_end.size() == 0) begin
          check("unexpected_end", {bus.BurstDone, bus.Error}, 2'b00);
        end else begin
          mon_kind = exp_end.pop_front();
          check("end_kind", {bus.BurstDone, bus.Error},
                (mon_kind == END_DONE) ? 2'b10 : 2'b01);
          if (mon_kind == END_DONE) check("words_per_burst", mon_next_cnt, 16);
          else                      check("start_cycles", mon_tx_cnt, 8);
          check("outputs_at_end", {bus.Grant, bus.Transmit, bus.Busy}, 6'b0);
        end
      end
      mon_prev = bus.Grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    client_data    = {16'h7E11, 16'hA5C3, 16'h3C5A, 16'h1234};
    bus.ClientData = client_data;
    bus.ClientReq  = 4'b0000;
    bus.Request    = 1'b0;
    bus.Ready      = 1'b0;

    // Single client 1 burst from reset.
    exp_grant.push_back(4'b0010);
    exp_end.push_back(END_DONE);
    do_reset(4'b0010);
    wait_transmit();
    send_words(16);
    bus.ClientReq = 4'b0000;
    repeat (3) tick();

    // All four requesting: 0,1,2,3,0.
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    repeat (5) exp_end.push_back(END_DONE);
    do_reset(4'b1111);
    for (int b = 0; b < 5; b++) begin
      wait_transmit();
      send_words(16);
    end
    bus.ClientReq = 4'b0000;
    repeat (3) tick();

    // Client 2 data path; its request drops mid-burst but the burst completes.
    exp_grant.push_back(4'b0100);
    exp_end.push_back(END_DONE);
    bus.ClientReq = 4'b0100;
    wait_transmit();
    send_words(3);
    bus.ClientReq = 4'b0000;
    check("tx_mid_burst", bus.TxData, 16'hA5C3);
    check("grant_held", bus.Grant, 4'b0100);
    send_words(13);
    repeat (3) tick();

    // Reset after 5 words of a client 2 burst.
    exp_grant.push_back(4'b0100);
    bus.ClientReq = 4'b0100;
    wait_transmit();
    send_words(5);
    Reset_n = 1'b0;
    #1;
    check("async_reset_mid_burst", out_bundle(), 28'h0);
    exp_grant.push_back(4'b0001);
    exp_end.push_back(END_DONE);
    bus.ClientReq = 4'b0101;
    tick();
    tick();
    Reset_n = 1'b1;
    #1;
    check("grant_after_midburst_release", bus.Grant, 4'b0000);
    wait_transmit();
    send_words(16);
    bus.ClientReq = 4'b0000;
    repeat (3) tick();

    // Start timeout, then the pointer must still favour client 0.
    exp_grant.push_back(4'b0001);
    exp_end.push_back(END_ERR);
    exp_grant.push_back(4'b0001);
    exp_end.push_back(END_DONE);
    do_reset(4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.Error) seen = 1'b1;
    end
    check("error_seen", seen, 1'b1);
    bus.ClientReq = 4'b0011;
    wait_transmit();
    send_words(16);
    bus.ClientReq = 4'b0000;
    repeat (4) tick();

    check("idle_grant", bus.Grant, 4'b0000);
    check("idle_txdata", bus.TxData, 16'h0000);
    check("grant_queue_empty", exp_grant.size(), 0);
    check("end_queue_empty", exp_end.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
